// File: rtl/lcd_panel_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lcd_panel_sequencer
//  Brief    : Power/link sequencer for an LVDS LCD panel (VDD, link, unblank,
//             backlight) with frame-start liveness check before backlight-on.
//             Optional backlight PWM output enabled by macro LCD_BL_PWM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_panel_sequencer #(
    parameter int T_VDD_LINK    = 1000000,
    parameter int T_LINK_VID    = 2000000,
    parameter int T_VID_BL      = 20000000,
    parameter int T_BL_VID      = 20000000,
    parameter int T_LINK_VDD    = 1000000,
    parameter int T_OFF_MIN     = 50000000,
    parameter int FRAME_TIMEOUT = 4000000,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_start,
`ifdef LCD_BL_PWM_EN
    input  logic [7:0] bl_level,
    output logic       bl_pwm,
`endif
    output logic       panel_vdd_en,
    output logic       link_en,
    output logic       video_en,
    output logic       bl_en,
    output logic       ready,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_PWR_UP    = 4'd1,
        S_LINK_UP   = 4'd2,
        S_SYNC      = 4'd3,
        S_VID_WAIT  = 4'd4,
        S_ON        = 4'd5,
        S_BL_OFF    = 4'd6,
        S_LINK_DOWN = 4'd7,
        S_VDD_OFF   = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] c_ld_vdd_link = CNT_W'(T_VDD_LINK - 1);
    localparam logic [CNT_W-1:0] c_ld_link_vid = CNT_W'(T_LINK_VID - 1);
    localparam logic [CNT_W-1:0] c_ld_timeout  = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ld_vid_bl   = CNT_W'(T_VID_BL - 1);
    localparam logic [CNT_W-1:0] c_ld_bl_vid   = CNT_W'(T_BL_VID - 1);
    localparam logic [CNT_W-1:0] c_ld_link_vdd = CNT_W'(T_LINK_VDD - 1);
    localparam logic [CNT_W-1:0] c_ld_off_min  = CNT_W'(T_OFF_MIN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;
    logic             r_fault;
    logic             w_fault_nxt;

    logic r_vdd, r_link, r_video, r_bl, r_ready, r_busy;
    logic w_vdd, w_link, w_video, w_bl, w_ready, w_busy;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : (r_cnt - 1'b1);
        w_fault_nxt = r_fault;
        unique case (r_state)
            S_OFF: begin
                if (!enable) begin
                    w_fault_nxt = 1'b0;
                end else if (!r_fault) begin
                    w_state_nxt = S_PWR_UP;
                    w_cnt_nxt   = c_ld_vdd_link;
                end
            end
            S_PWR_UP: begin
                if (!enable) begin
                    w_state_nxt = S_VDD_OFF;
                    w_cnt_nxt   = c_ld_off_min;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_LINK_UP;
                    w_cnt_nxt   = c_ld_link_vid;
                end
            end
            S_LINK_UP: begin
                if (!enable) begin
                    w_state_nxt = S_LINK_DOWN;
                    w_cnt_nxt   = c_ld_link_vdd;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_SYNC;
                    w_cnt_nxt   = c_ld_timeout;
                end
            end
            S_SYNC: begin
                // Abort beats a coincident frame pulse; a pulse beats the timeout.
                if (!enable) begin
                    w_state_nxt = S_LINK_DOWN;
                    w_cnt_nxt   = c_ld_link_vdd;
                end else if (frame_start) begin
                    w_state_nxt = S_VID_WAIT;
                    w_cnt_nxt   = c_ld_vid_bl;
                end else if (w_cnt_zero) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = S_LINK_DOWN;
                    w_cnt_nxt   = c_ld_link_vdd;
                end
            end
            S_VID_WAIT: begin
                if (!enable) begin
                    w_state_nxt = S_BL_OFF;
                    w_cnt_nxt   = c_ld_bl_vid;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_ON;
                end
            end
            S_ON: begin
                if (!enable) begin
                    w_state_nxt = S_BL_OFF;
                    w_cnt_nxt   = c_ld_bl_vid;
                end
            end
            S_BL_OFF: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_LINK_DOWN;
                    w_cnt_nxt   = c_ld_link_vdd;
                end
            end
            S_LINK_DOWN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_VDD_OFF;
                    w_cnt_nxt   = c_ld_off_min;
                end
            end
            S_VDD_OFF: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_OFF;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        w_vdd   = 1'b0;
        w_link  = 1'b0;
        w_video = 1'b0;
        w_bl    = 1'b0;
        w_ready = 1'b0;
        w_busy  = (w_state_nxt != S_OFF) && (w_state_nxt != S_ON);
        unique case (w_state_nxt)
            S_PWR_UP, S_LINK_DOWN: w_vdd = 1'b1;
            S_LINK_UP, S_SYNC: begin
                w_vdd  = 1'b1;
                w_link = 1'b1;
            end
            S_VID_WAIT, S_BL_OFF: begin
                w_vdd   = 1'b1;
                w_link  = 1'b1;
                w_video = 1'b1;
            end
            S_ON: begin
                w_vdd   = 1'b1;
                w_link  = 1'b1;
                w_video = 1'b1;
                w_bl    = 1'b1;
                w_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_vdd   <= 1'b0;
            r_link  <= 1'b0;
            r_video <= 1'b0;
            r_bl    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
            r_vdd   <= w_vdd;
            r_link  <= w_link;
            r_video <= w_video;
            r_bl    <= w_bl;
            r_ready <= w_ready;
            r_busy  <= w_busy;
        end
    end

    assign panel_vdd_en = r_vdd;
    assign link_en      = r_link;
    assign video_en     = r_video;
    assign bl_en        = r_bl;
    assign ready        = r_ready;
    assign busy         = r_busy;
    assign fault        = r_fault;

`ifdef LCD_BL_PWM_EN
    logic [7:0] r_pwm_cnt;
    logic [7:0] r_bl_level_q;
    logic       r_bl_pwm;

    // Level is latched only at the period boundary to avoid runt pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm_cnt    <= 8'd0;
            r_bl_level_q <= 8'd0;
            r_bl_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (r_pwm_cnt == 8'hFF) begin
                r_bl_level_q <= bl_level;
            end
            r_bl_pwm <= r_bl && (r_pwm_cnt < r_bl_level_q);
        end
    end

    assign bl_pwm = r_bl_pwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_panel_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_panel_sequencer
//  Brief    : Scoreboard bench: phase/deadline reference model predicts output
//             changes, monitor compares every observed change.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_panel_sequencer;

    localparam int P_VDD_LINK = 4;
    localparam int P_LINK_VID = 6;
    localparam int P_VID_BL   = 3;
    localparam int P_BL_VID   = 3;
    localparam int P_LINK_VDD = 5;
    localparam int P_OFF_MIN  = 8;
    localparam int P_TIMEOUT  = 20;

    // Phases: 0 OFF 1 PWR_UP 2 LINK_UP 3 SYNC 4 VID_WAIT 5 ON 6 BL_OFF 7 LINK_DOWN 8 VDD_OFF
    localparam int DWELL[9] = '{0, P_VDD_LINK, P_LINK_VID, P_TIMEOUT, P_VID_BL, 0,
                                P_BL_VID, P_LINK_VDD, P_OFF_MIN};
    localparam int NEXT[9]  = '{0, 2, 3, 7, 5, 5, 7, 8, 0};
    localparam int ABORT[9] = '{-1, 8, 7, 7, 6, 6, -1, -1, -1};
    localparam logic [3:0] RAILS[9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1100, 4'b1110,
                                        4'b1111, 4'b1110, 4'b1000, 4'b0000};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic frame_start = 1'b0;
    logic panel_vdd_en, link_en, video_en, bl_en, ready, busy, fault;
`ifdef LCD_BL_PWM_EN
    logic [7:0] bl_level = 8'd0;
    logic       bl_pwm;
`endif

    always #5 clk = ~clk;

    lcd_panel_sequencer #(
        .T_VDD_LINK    (P_VDD_LINK),
        .T_LINK_VID    (P_LINK_VID),
        .T_VID_BL      (P_VID_BL),
        .T_BL_VID      (P_BL_VID),
        .T_LINK_VDD    (P_LINK_VDD),
        .T_OFF_MIN     (P_OFF_MIN),
        .FRAME_TIMEOUT (P_TIMEOUT),
        .CNT_W         (26)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .frame_start  (frame_start),
`ifdef LCD_BL_PWM_EN
        .bl_level     (bl_level),
        .bl_pwm       (bl_pwm),
`endif
        .panel_vdd_en (panel_vdd_en),
        .link_en      (link_en),
        .video_en     (video_en),
        .bl_en        (bl_en),
        .ready        (ready),
        .busy         (busy),
        .fault        (fault)
    );

    logic [6:0] dut_vec;
    assign dut_vec = {panel_vdd_en, link_en, video_en, bl_en, ready, busy, fault};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         c;
        logic [6:0] v;
    } ev_t;
    ev_t sbq[$];

    int         m_phase    = 0;
    int         m_deadline = 0;
    bit         m_fault    = 1'b0;
    logic [6:0] m_last     = 7'd0;

    function automatic logic [6:0] exp_vec(input int p, input bit f);
        return {RAILS[p], (p == 5), (p != 0 && p != 5), f};
    endfunction

    task enter(input int p);
        m_phase    = p;
        m_deadline = cyc + DWELL[p];
    endtask

    // Reference model: one step per clock edge, deadlines kept as absolute cycle numbers.
    always @(posedge clk) begin
        logic [6:0] v;
        if (!rst) begin
            m_phase = 0;
            m_fault = 1'b0;
        end else if (m_phase == 0) begin
            if (!enable) m_fault = 1'b0;
            else if (!m_fault) enter(1);
        end else if (!enable && ABORT[m_phase] >= 0) begin
            enter(ABORT[m_phase]);
        end else if (m_phase == 3 && frame_start) begin
            enter(4);
        end else if (DWELL[m_phase] > 0 && cyc == m_deadline) begin
            if (m_phase == 3) m_fault = 1'b1;
            enter(NEXT[m_phase]);
        end
        cyc = cyc + 1;
        v = exp_vec(m_phase, m_fault);
        if (v != m_last) begin
            sbq.push_back('{cyc, v});
            m_last = v;
        end
    end

    logic [6:0] mon_prev = 7'd0;
    always @(posedge clk) begin
        ev_t e;
        #1;
        if (dut_vec !== mon_prev) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: cycle %0d got %b want no change", cyc, dut_vec);
            end else begin
                e = sbq.pop_front();
                if (e.c != cyc || e.v !== dut_vec) begin
                    bad++;
                    $display("FAIL sb_event: got %b at cycle %0d want %b at cycle %0d",
                             dut_vec, cyc, e.v, e.c);
                end
            end
            mon_prev = dut_vec;
        end
    end

    task automatic drive(input bit en, input bit fs, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable      = en;
            frame_start = fs;
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if (dut_vec !== 7'd0) begin
            bad++;
            $display("FAIL %s: outputs %b want 0000000", name, dut_vec);
        end
    endtask

    initial begin
        drive(0, 0, 3);
        check_zero("reset_state");
        rst = 1'b1;
        drive(0, 0, 2);

        // Nominal power-up with pulse at cycle 15, then power-down
        drive(1, 0, 15);
        drive(1, 1, 1);
        drive(1, 0, 10);
        drive(0, 0, 25);

        // Frame timeout, stuck fault, clear, re-power
        drive(1, 0, 45);
        drive(0, 0, 3);
        drive(1, 0, 30);
        drive(0, 0, 40);

        // Abort in PWR_UP, enable ignored during VDD_OFF
        drive(1, 0, 2);
        drive(0, 0, 3);
        drive(1, 0, 20);
        drive(0, 0, 40);

        // Abort and frame pulse coincide in SYNC
        drive(1, 0, 13);
        drive(0, 1, 1);
        drive(0, 0, 30);

        // Frame pulse exactly on the timeout cycle
        drive(1, 0, 30);
        drive(1, 1, 1);
        drive(1, 0, 10);

        // Asynchronous reset while ON
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 30);
        drive(0, 0, 30);

        // Randomized enable levels with sparse frame pulses
        for (int s = 0; s < 40; s++) begin
            bit en;
            int n;
            en = ($urandom_range(0, 3) != 0);
            n  = $urandom_range(1, 50);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                enable      = en;
                frame_start = ($urandom_range(0, 7) == 0);
            end
        end
        drive(0, 0, 40);

`ifdef LCD_BL_PWM_EN
        begin
            int highs;
            drive(1, 1, 20);
            bl_level = 8'd64;
            drive(1, 0, 512);
            highs = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (bl_pwm) highs++;
            end
            total++;
            if (highs != 64) begin
                bad++;
                $display("FAIL pwm_64: high %0d of 256 want 64", highs);
            end
            bl_level = 8'd0;
            drive(1, 0, 512);
            highs = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (bl_pwm) highs++;
            end
            total++;
            if (highs != 0) begin
                bad++;
                $display("FAIL pwm_0: high %0d of 256 want 0", highs);
            end
            drive(0, 0, 40);
        end
`endif

        @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d expected events never seen want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_panel_sequencer.md
Name: lcd_panel_sequencer

Overview:
Power and link sequencer for the LVDS LCD panel path. It drives the panel power rail enable, the LVDS serializer/output enable, the video unblank and the backlight enable, each in the order and with the dwell times the panel datasheet requires. It confirms the pixel stream is alive, using the frame-start pulse from the timing generator, before the backlight is turned on. It sits beside the core/serializer, and all of its outputs gate that datapath.

Parameters:
T_VDD_LINK, 1000000, cycles from panel_vdd_en high to link_en high (≥1)
T_LINK_VID, 2000000, cycles from link_en high to start of frame-sync wait (≥1)
T_VID_BL, 20000000, cycles from video_en high to bl_en high (≥1)
T_BL_VID, 20000000, cycles from bl_en low to video_en/link_en low (≥1)
T_LINK_VDD, 1000000, cycles from link_en low to panel_vdd_en low (≥1)
T_OFF_MIN, 50000000, minimum cycles panel_vdd_en stays low before a new power-up (≥1)
FRAME_TIMEOUT, 4000000, maximum cycles to wait for frame_start (≥1)
CNT_W, 26, width of the dwell/timeout counter; must hold the largest parameter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
enable  in  1  level request: 1 = panel on, 0 = panel off
frame_start  in  1  single-cycle pulse from the timing generator at each frame start
panel_vdd_en  out  1  panel logic supply enable
link_en  out  1  LVDS serializer and output-buffer enable
video_en  out  1  unblank; 0 forces black pixel data
bl_en  out  1  backlight enable
ready  out  1  1 only in state ON
busy  out  1  1 in every state except OFF and ON
fault  out  1  sticky; frame_start not seen within FRAME_TIMEOUT

Behaviour:
- Reset (rst=0, asynchronous): state OFF, counter 0, every output 0.
- One down-counter. Entering a timed state loads it with T-1. The state exits on the cycle the counter reads 0, so the dwell is exactly T cycles.
- Outputs are registered and are a function of the state only:
  - OFF: all 0
  - PWR_UP: vdd
  - LINK_UP, SYNC: vdd, link
  - VID_WAIT: vdd, link, video
  - ON: vdd, link, video, bl, ready
  - BL_OFF: vdd, link, video
  - LINK_DOWN: vdd
  - VDD_OFF: all 0
- Transitions:
  - OFF → PWR_UP when enable=1 and fault=0.
  - PWR_UP → LINK_UP after T_VDD_LINK.
  - LINK_UP → SYNC after T_LINK_VID.
  - SYNC: the counter is loaded with FRAME_TIMEOUT-1. frame_start=1 → VID_WAIT. Counter reaches 0 with no pulse → set fault, go to LINK_DOWN.
  - VID_WAIT → ON after T_VID_BL.
  - ON holds while enable=1.
  - BL_OFF → LINK_DOWN after T_BL_VID.
  - LINK_DOWN → VDD_OFF after T_LINK_VDD.
  - VDD_OFF → OFF after T_OFF_MIN.
- enable=0 on the way up unwinds from the current point:
  - PWR_UP → VDD_OFF
  - LINK_UP or SYNC → LINK_DOWN
  - VID_WAIT → BL_OFF
  - ON → BL_OFF
- enable=1 during BL_OFF, LINK_DOWN or VDD_OFF is ignored. The sequence finishes to OFF, then restarts if enable is still 1.
- Simultaneous events in SYNC: frame_start=1 and enable=0 in the same cycle → enable wins (LINK_DOWN, no fault). frame_start=1 on the timeout cycle → VID_WAIT, no fault.
- fault clears only in OFF with enable=0. While fault=1, OFF does not restart.
- frame_start is ignored in every state except SYNC.

Optional Feature:
- Macro: LCD_BL_PWM_EN.
- Defined:
  - Adds input bl_level[7:0] and output bl_pwm.
  - An 8-bit free-running counter runs from reset at 0.
  - bl_pwm is registered as bl_en AND (pwm_cnt < bl_level). Period is 256 cycles; bl_level=0 gives constant 0.
  - bl_level is sampled only at pwm_cnt=255, so changes take effect glitch-free.
- Undefined: neither port nor the counter exists; bl_en alone controls the backlight.

Test Plan:
All tests use T_VDD_LINK=4, T_LINK_VID=6, T_VID_BL=3, T_BL_VID=3, T_LINK_VDD=5, T_OFF_MIN=8, FRAME_TIMEOUT=20.
- Power-up: enable=1 at cycle 0 → vdd at 1, link at 5, SYNC at 11; frame_start pulsed at 15 → video at 16, bl and ready at 19.
- Power-down: from ON, enable=0 → bl low next cycle; video/link low 3 cycles later; vdd low 5 cycles after that; OFF 8 cycles after that; busy high throughout.
- Timeout: no frame_start → fault=1 and link low 20 cycles after SYNC entry; stays in OFF with enable=1; enable=0 clears fault; enable=1 re-powers.
- Abort: enable=0 two cycles into PWR_UP → VDD_OFF, vdd low next cycle; enable=1 mid VDD_OFF ignored; power-up starts only after 8 low cycles.
- Reset: rst=0 while in ON → all outputs 0 immediately, with no clock edge needed; rst=1 with enable=1 → normal power-up.
- PWM (LCD_BL_PWM_EN): bl_level=64 in ON → bl_pwm high 64 of every 256 cycles; bl_level=0 → bl_pwm constant 0.
